// File: rtl/pipeline_mem_pkg.sv
// Shared pipeline types: debug bundle, MEM-stage control word, MEM FSM states
// and the RV32I load/store funct3 encodings.
package pipeline_mem_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } Debug_t;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       Branch;
    logic       Jump;
    logic [2:0] funct3;
    logic [4:0] rd;
  } MemCtrl_t;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/pipeline_mem_align.sv
// Combinational data-memory lane logic: byte enables, store replication,
// load extraction/extension and alignment check.
module mem_align
  import pipeline_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        mem_op,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);
  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (funct3[1:0])
      F3_B[1:0]: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H[1:0]: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_data  = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misaligned = mem_op & addr_lo[0];
      end
      default: misaligned = mem_op & (|addr_lo);
    endcase
  end
endmodule

// File: rtl/pipeline_mem.sv
// RV32I MEM stage: stage register, data-memory handshake FSM, branch redirect
// and writeback register.
module pipeline_mem
  import pipeline_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  Debug_t      debug_in_MEM,
  output Debug_t      debug_out_MEM,
  input  logic        valid_in,
  input  MemCtrl_t    ctrl_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] Rs2_in,
  input  logic [31:0] PC_target_in,
  input  logic [31:0] PC4_in,
  input  logic        zero_in,
  output logic        stall_out,
  output logic        PCSrc_out,
  output logic [31:0] PC_target_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_out
);
  logic        valid_q, zero_q;
  MemCtrl_t    ctrl_q;
  logic [31:0] alu_q, rs2_q, target_q, pc4_q;
  Debug_t      debug_q;
  mem_state_t  state, state_nxt;

  logic        mem_op, misaligned, pending, retire;
  logic [31:0] load_data;

  mem_align u_align (
    .funct3    (ctrl_q.funct3),
    .addr_lo   (alu_q[1:0]),
    .mem_op    (mem_op),
    .store_data(rs2_q),
    .rdata     (dmem_rdata),
    .be        (dmem_be),
    .wdata     (dmem_wdata),
    .load_data (load_data),
    .misaligned(misaligned)
  );

  assign mem_op        = valid_q & (ctrl_q.MemRead | ctrl_q.MemWrite);
  assign pending       = mem_op & ~misaligned;
  assign stall_out     = pending & ~dmem_ack;
  assign retire        = valid_q & (~(ctrl_q.MemRead | ctrl_q.MemWrite) | misaligned | dmem_ack);
  assign dmem_req      = pending;
  assign dmem_we       = pending & ctrl_q.MemWrite;
  assign dmem_addr     = alu_q;
  assign PCSrc_out     = valid_q & (ctrl_q.Jump | (ctrl_q.Branch & zero_q));
  assign PC_target_out = target_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending && !dmem_ack) state_nxt = WAIT;
      WAIT:    if (dmem_ack || !pending) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid_q       <= 1'b0;
      zero_q        <= 1'b0;
      ctrl_q        <= '0;
      alu_q         <= '0;
      rs2_q         <= '0;
      target_q      <= '0;
      pc4_q         <= '0;
      debug_q       <= '0;
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      misalign_out  <= 1'b0;
      debug_out_MEM <= '0;
    end else begin
      state <= state_nxt;
      if (!stall_out) begin
        valid_q  <= valid_in;
        zero_q   <= zero_in;
        ctrl_q   <= ctrl_in;
        alu_q    <= ALU_in;
        rs2_q    <= Rs2_in;
        target_q <= PC_target_in;
        pc4_q    <= PC4_in;
        debug_q  <= debug_in_MEM;
      end
      misalign_out <= retire & misaligned;
      if (retire) begin
        wb_valid      <= ~misaligned;
        wb_RegWrite   <= ctrl_q.RegWrite & ~misaligned & (|ctrl_q.rd);
        wb_rd         <= ctrl_q.rd;
        wb_data       <= ctrl_q.MemRead ? load_data : ctrl_q.Jump ? pc4_q : alu_q;
        debug_out_MEM <= debug_q;
      end else begin
        wb_valid    <= 1'b0;
        wb_RegWrite <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_mem.sv
// Directed bench for pipeline_mem: expected writebacks go into a scoreboard
// queue, a forked monitor pops and compares them whenever wb_valid is seen.
module tb_pipeline_mem;
  import pipeline_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  Debug_t      debug_in_MEM, debug_out_MEM;
  logic        valid_in;
  MemCtrl_t    ctrl_in;
  logic [31:0] ALU_in, Rs2_in, PC_target_in, PC4_in;
  logic        zero_in;
  logic        stall_out, PCSrc_out;
  logic [31:0] PC_target_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_RegWrite, misalign_out;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  pipeline_mem dut (
    .clk(clk), .rst(rst), .debug_in_MEM(debug_in_MEM), .debug_out_MEM(debug_out_MEM),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .ALU_in(ALU_in), .Rs2_in(Rs2_in),
    .PC_target_in(PC_target_in), .PC4_in(PC4_in), .zero_in(zero_in),
    .stall_out(stall_out), .PCSrc_out(PCSrc_out), .PC_target_out(PC_target_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_wb_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          chk("wb_RegWrite", {31'b0, wb_RegWrite}, {31'b0, e.rw});
          chk("debug_pc", debug_out_MEM.pc, e.pc);
        end
      end
    end
  endtask

  function automatic MemCtrl_t mk(input logic r, w, rw, b, j, input logic [2:0] f3,
                                  input logic [4:0] rd);
    MemCtrl_t c;
    c.MemRead = r; c.MemWrite = w; c.RegWrite = rw; c.Branch = b; c.Jump = j;
    c.funct3 = f3; c.rd = rd;
    return c;
  endfunction

  task automatic push(input logic [4:0] rd, input logic rw, input logic [31:0] data,
                      input logic [31:0] pc);
    exp_t e;
    e.rd = rd; e.rw = rw; e.data = data; e.pc = pc;
    q.push_back(e);
  endtask

  // Called just after a rising edge; leaves the op in the stage register.
  task automatic send(input MemCtrl_t c, input logic [31:0] alu, rs2, tgt, pc4,
                      input logic z);
    ctrl_in = c; ALU_in = alu; Rs2_in = rs2; PC_target_in = tgt; PC4_in = pc4;
    zero_in = z; debug_in_MEM.pc = pc4 - 32'd4; debug_in_MEM.insn = 32'h13;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fork monitor(); join_none
    rst = 1'b1; valid_in = 1'b0; ctrl_in = '0; ALU_in = '0; Rs2_in = '0;
    PC_target_in = '0; PC4_in = '0; zero_in = 1'b0; debug_in_MEM = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_out}, 32'd0);
    chk("rst_pcsrc", {31'b0, PCSrc_out}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    step(); rst = 1'b0;

    // lw, zero-wait memory
    push(5'd5, 1'b1, 32'h89ABCDEF, 32'h1000);
    send(mk(1, 0, 1, 0, 0, F3_W, 5'd5), 32'h100, 0, 0, 32'h1004, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h89ABCDEF;
    @(negedge clk);
    chk("lw_req", {31'b0, dmem_req}, 32'd1);
    chk("lw_stall", {31'b0, stall_out}, 32'd0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_we", {31'b0, dmem_we}, 32'd0);
    step(); dmem_ack = 1'b0;

    // lb at byte 3, three wait cycles
    push(5'd6, 1'b1, 32'hFFFFFF80, 32'h1004);
    send(mk(1, 0, 1, 0, 0, F3_B, 5'd6), 32'h103, 0, 0, 32'h1008, 0);
    dmem_rdata = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lb_stall", {31'b0, stall_out}, 32'd1);
      chk("lb_req_held", {31'b0, dmem_req}, 32'd1);
      chk("lb_addr_held", dmem_addr, 32'h103);
      step();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("lb_stall_ack", {31'b0, stall_out}, 32'd0);
    step(); dmem_ack = 1'b0;

    // lh / lhu at 0x102
    dmem_rdata = 32'h8001_1234;
    push(5'd7, 1'b1, 32'hFFFF8001, 32'h1008);
    send(mk(1, 0, 1, 0, 0, F3_H, 5'd7), 32'h102, 0, 0, 32'h100C, 0);
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
    push(5'd8, 1'b1, 32'h00008001, 32'h100C);
    send(mk(1, 0, 1, 0, 0, F3_HU, 5'd8), 32'h102, 0, 0, 32'h1010, 0);
    dmem_ack = 1'b1; step(); dmem_ack = 1'b0;

    // sh at 0x202
    push(5'd0, 1'b0, 32'h202, 32'h1010);
    send(mk(0, 1, 0, 0, 0, F3_H, 5'd0), 32'h202, 32'h0000BEEF, 0, 32'h1014, 0);
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("sh_be", {28'b0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_we", {31'b0, dmem_we}, 32'd1);
    step(); dmem_ack = 1'b0;

    // sb at 0x201
    push(5'd0, 1'b0, 32'h201, 32'h1014);
    send(mk(0, 1, 0, 0, 0, F3_B, 5'd0), 32'h201, 32'h000000A5, 0, 32'h1018, 0);
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("sb_be", {28'b0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    step(); dmem_ack = 1'b0;

    // misaligned lw
    send(mk(1, 0, 1, 0, 0, F3_W, 5'd9), 32'h101, 0, 0, 32'h101C, 0);
    @(negedge clk);
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall_out}, 32'd0);
    step();
    @(negedge clk);
    chk("mis_pulse", {31'b0, misalign_out}, 32'd1);
    chk("mis_wb_valid", {31'b0, wb_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("mis_pulse_end", {31'b0, misalign_out}, 32'd0);
    step();

    // beq taken
    push(5'd0, 1'b0, 32'h0, 32'h1020);
    send(mk(0, 0, 0, 1, 0, F3_B, 5'd0), 32'h0, 0, 32'h40, 32'h1024, 1);
    @(negedge clk);
    chk("beq_pcsrc", {31'b0, PCSrc_out}, 32'd1);
    chk("beq_target", PC_target_out, 32'h40);
    step();
    @(negedge clk);
    chk("beq_pcsrc_end", {31'b0, PCSrc_out}, 32'd0);
    step();

    // jal rd=1
    push(5'd1, 1'b1, 32'h2008, 32'h2004);
    send(mk(0, 0, 1, 0, 1, F3_B, 5'd1), 32'h3000, 0, 32'h3000, 32'h2008, 0);
    @(negedge clk);
    chk("jal_pcsrc", {31'b0, PCSrc_out}, 32'd1);
    step();

    // ALU op to x0: write suppressed
    push(5'd0, 1'b0, 32'h55, 32'h2008);
    send(mk(0, 0, 1, 0, 0, F3_B, 5'd0), 32'h55, 0, 0, 32'h200C, 0);
    step();

    // spurious ack with nothing pending
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("spur_req", {31'b0, dmem_req}, 32'd0);
    step(); dmem_ack = 1'b0;

    // reset during WAIT, late ack ignored
    send(mk(1, 0, 1, 0, 0, F3_W, 5'd10), 32'h300, 0, 0, 32'h3004, 0);
    @(negedge clk);
    chk("rw_req_before", {31'b0, dmem_req}, 32'd1);
    step(); rst = 1'b1;
    step(); rst = 1'b0; dmem_ack = 1'b1;
    @(negedge clk);
    chk("rw_req_after", {31'b0, dmem_req}, 32'd0);
    chk("rw_stall_after", {31'b0, stall_out}, 32'd0);
    step(); dmem_ack = 1'b0;
    @(negedge clk);
    chk("rw_wb_valid", {31'b0, wb_valid}, 32'd0);
    repeat (3) step();

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
